// File: rtl/dm_responder.sv
// Data-memory responder for the multicycle core's Mem phase.
// Single word request with fixed wait states, byte-enabled writes.
module dm_responder #(
   parameter int ADDR_W = 8,
   parameter int WAIT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [3:0] WAIT_M1 =
      (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic        we_q,    we_d;
   logic [31:0] addr_q,  addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q,    be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q,   err_d;

   logic [31:0] mem [DEPTH];

   logic              go_resp;
   logic              acc_we;
   logic [31:0]       acc_addr;
   logic [31:0]       acc_wdata;
   logic [3:0]        acc_be;
   logic              acc_bad;
   logic [ADDR_W-1:0] acc_idx;
   logic              mem_wr;

   // Select the access operands; with no wait states they come
   // straight from the request inputs on the capturing edge.
   always_comb begin
      go_resp = 1'b0;
      if (state_q == S_IDLE) begin
         go_resp = req && (WAIT == 0);
      end else if (state_q == S_WAIT) begin
         go_resp = (cnt_q == 4'd0);
      end
      if (state_q == S_IDLE) begin
         acc_we    = we;
         acc_addr  = addr;
         acc_wdata = wdata;
         acc_be    = be;
      end else begin
         acc_we    = we_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_be    = be_q;
      end
      acc_bad = (acc_addr[1:0] != 2'b00) ||
                ((acc_addr >> (ADDR_W + 2)) != 32'd0);
      acc_idx = acc_addr[ADDR_W+1:2];
      mem_wr  = go_resp && acc_we && !acc_bad && !rst;
   end

   // Next-state, request capture and response registers.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               be_d    = be;
               if (WAIT == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_M1;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (go_resp) begin
         err_d = acc_bad;
         if (acc_bad) begin
            rdata_d = 32'd0;
         end else if (!acc_we) begin
            rdata_d = mem[acc_idx];
         end
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Byte-enabled write on the edge entering RESP; no reset on storage.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   assign ack   = (state_q == S_RESP);
   assign rdata = rdata_q;
   assign err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed scenarios plus random traffic
// checked against a word-array memory model.
module tb_dm_responder;

   localparam int ADDR_W = 8;
   localparam int WAIT   = 2;
   localparam int DEPTH  = 1 << ADDR_W;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  be = 4'd0;
   logic        ack;
   logic [31:0] rdata;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m [DEPTH];
   logic [31:0] exp_rdata = 32'd0;
   logic [31:0] ha [3];

   dm_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we),
      .addr(addr), .wdata(wdata), .be(be),
      .ack(ack), .rdata(rdata), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transaction starting in the current IDLE cycle; returns
   // in the IDLE cycle after ack.
   task automatic txn(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      output logic [31:0] rd);
      logic        bad;
      logic [31:0] exp_rd;
      logic [31:0] hold;
      int          idx;
      bad = (a % 4 != 0) || (a >= 32'(4 * DEPTH));
      idx = int'(a / 4);
      exp_rd = exp_rdata;
      if (bad) exp_rd = 32'd0;
      else if (!w) exp_rd = mem_m[idx];
      hold = exp_rdata;
      rd = 32'hx;
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      for (int c = 1; c <= WAIT + 2; c++) begin
         step();
         if (c == 1) req = 1'b0;
         if (c == WAIT + 1) begin
            chk("ack_pulse", 32'(ack), 32'd1);
            chk("err_resp", 32'(err), 32'(bad));
            chk("rdata_resp", rdata, exp_rd);
            rd = rdata;
            hold = exp_rd;
         end else begin
            chk("ack_idle", 32'(ack), 32'd0);
            chk("err_idle", 32'(err), 32'd0);
            chk("rdata_hold", rdata, hold);
         end
      end
      exp_rdata = exp_rd;
      if (w && !bad) begin
         for (int i = 0; i < 4; i++)
            if (b[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      int          k;
      int          sel;

      ha[0] = 32'h10; ha[1] = 32'h20; ha[2] = 32'h0;

      #2 rst = 1'b1;
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      step(); step();
      rst = 1'b0;
      step();

      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
      txn(1'b0, 32'h10, 32'h0, 4'h0, rd);
      chk("rd_deadbeef", rd, 32'hDEADBEEF);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_after_read", rdata, 32'hDEADBEEF);
         chk("hold_ack", 32'(ack), 32'd0);
      end

      txn(1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd);
      txn(1'b0, 32'h10, 32'h0, 4'h0, rd);
      chk("rd_byte_merge", rd, 32'hDEADAAEF);

      txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd);
      txn(1'b0, 32'h12, 32'h0, 4'h0, rd);
      chk("rd_misaligned", rd, 32'd0);
      txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd);
      txn(1'b0, 32'h0, 32'h0, 4'h0, rd);
      chk("rd_word0_intact", rd, 32'h0BADF00D);

      txn(1'b1, 32'h20, 32'h11111111, 4'hF, rd);
      req = 1'b1; we = 1'b1; addr = 32'h20;
      wdata = 32'h22222222; be = 4'hF;
      step();
      req = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_ack", 32'(ack), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      step();
      rst = 1'b0;
      exp_rdata = 32'd0;
      for (int i = 0; i < WAIT + 2; i++) begin
         step();
         chk("post_rst_noack", 32'(ack), 32'd0);
      end
      txn(1'b0, 32'h20, 32'h0, 4'h0, rd);
      chk("rd_after_rst", rd, 32'h11111111);

      k = 0;
      we = 1'b0; addr = ha[0]; req = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 9) req = 1'b0;
         if (c == 10) req = 1'b1;
         if (c == 12) req = 1'b0;
         if (c == 3 || c == 7 || c == 11) begin
            chk("stream_ack", 32'(ack), 32'd1);
            chk("stream_err", 32'(err), 32'd0);
            chk("stream_rdata", rdata, mem_m[ha[k] / 4]);
            exp_rdata = mem_m[ha[k] / 4];
            k++;
            if (k < 3) addr = ha[k];
         end else begin
            chk("stream_noack", 32'(ack), 32'd0);
         end
      end
      step();
      chk("stream_end", 32'(ack), 32'd0);

      for (int i = 0; i < 32; i++)
         txn(1'b1, 32'(i * 4), $urandom, 4'hF, rd);
      for (int n = 0; n < 60; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 8)
            a = 32'($urandom_range(0, 31) * 4);
         else if (sel == 8)
            a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
         else
            a = $urandom | 32'h400;
         txn(1'($urandom_range(0, 1)), a, $urandom,
             4'($urandom_range(0, 15)), rd);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
